// File: rtl/img2col_gbuf_feeder.sv
// img2col_gbuf_feeder
//   Producer side of the global-buffer column handshake. Packs kernel_size
//   pixels of one image column into buffer addresses 0..kernel_size-1, then
//   holds the column until the controller strobes r_ctrl_g. It walks through
//   img_width columns per row band and pulses done after the last one is read.
// Ports
//   clk, nrst          clock, asynchronous active-low reset
//   start              begin a row band (taken in IDLE only)
//   s_data/s_valid     pixel stream in; s_ready = feeder is filling
//   wr_data_g/adrs_out global-buffer write word and address
//   wr_ctrl_g          global-buffer write strobe, one cycle after accept
//   r_ctrl_g           controller finished reading the column
//   round              column index held in the buffer
//   neighbour_in_flag  round != 0 while busy
//   busy, done         not idle / one-cycle end-of-band pulse
module img2col_gbuf_feeder #(
  parameter int unsigned data_width  = 16,
  parameter int unsigned address_num = 5,
  parameter int unsigned kernel_size = 5,
  parameter int unsigned img_width   = 28
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  input  logic [data_width-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [data_width-1:0]  wr_data_g,
  output logic [address_num-1:0] adrs_out,
  output logic                   wr_ctrl_g,
  input  logic                   r_ctrl_g,
  output logic [5:0]             round,
  output logic                   neighbour_in_flag,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned round_w = 6;

  typedef enum logic [1:0] {IDLE, FILL, WAIT_RD, DONE} state_t;

  state_t                 state, state_nxt;
  logic [address_num-1:0] cnt, cnt_nxt, adrs_nxt;
  logic [data_width-1:0]  data_nxt;
  logic [round_w-1:0]     round_nxt;
  logic                   wr_nxt, s_ready_nxt, busy_nxt, done_nxt, nbr_nxt;
  logic                   accept, last_pix, last_col, rd_ok;

  assign accept   = (state == FILL) & s_valid & s_ready;
  assign last_pix = (cnt == address_num'(kernel_size - 1));
  assign last_col = (round == round_w'(img_width - 1));
  // A read strobe coinciding with the final write strobe is too early.
  assign rd_ok    = (state == WAIT_RD) & r_ctrl_g & ~wr_ctrl_g;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (accept && last_pix) state_nxt = WAIT_RD;
      WAIT_RD: if (rd_ok) state_nxt = last_col ? DONE : FILL;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and fill counter.
  always_comb begin
    cnt_nxt   = cnt;
    round_nxt = round;
    wr_nxt    = 1'b0;
    adrs_nxt  = adrs_out;
    data_nxt  = wr_data_g;
    case (state)
      IDLE: begin
        if (start) begin
          round_nxt = '0;
          cnt_nxt   = '0;
        end
      end
      FILL: begin
        if (accept) begin
          wr_nxt   = 1'b1;
          adrs_nxt = cnt;
          data_nxt = s_data;
          cnt_nxt  = last_pix ? '0 : cnt + address_num'(1);
        end
      end
      WAIT_RD: begin
        if (rd_ok && !last_col) round_nxt = round + round_w'(1);
      end
      DONE:    round_nxt = '0;
      default: round_nxt = '0;
    endcase
    s_ready_nxt = (state_nxt == FILL);
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == DONE);
    nbr_nxt     = busy_nxt & (round_nxt != '0);
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt               <= '0;
      round             <= '0;
      wr_ctrl_g         <= 1'b0;
      adrs_out          <= '0;
      wr_data_g         <= '0;
      s_ready           <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      neighbour_in_flag <= 1'b0;
    end else begin
      cnt               <= cnt_nxt;
      round             <= round_nxt;
      wr_ctrl_g         <= wr_nxt;
      adrs_out          <= adrs_nxt;
      wr_data_g         <= data_nxt;
      s_ready           <= s_ready_nxt;
      busy              <= busy_nxt;
      done              <= done_nxt;
      neighbour_in_flag <= nbr_nxt;
    end
  end

endmodule

// File: tb/tb_img2col_gbuf_feeder.sv
// tb_img2col_gbuf_feeder
//   Drives img2col_gbuf_feeder (kernel 5, 3 columns per band) with directed
//   sequences and random traffic, and compares every cycle against a
//   column/pixel-count model of the handshake.
module tb_img2col_gbuf_feeder;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;
  localparam int unsigned K  = 5;
  localparam int unsigned W  = 3;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] wr_data_g;
  logic [AW-1:0] adrs_out;
  logic          wr_ctrl_g;
  logic          r_ctrl_g = 1'b0;
  logic [5:0]    round;
  logic          neighbour_in_flag;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  // Model: band active, column index, pixels held for this column (0..K),
  // done pending, and the expected buffer write of the last cycle.
  bit          m_active;
  int          m_col;
  int          m_pix;
  bit          m_done;
  bit          e_wr;
  int          e_adr;
  logic [DW-1:0] e_data;

  img2col_gbuf_feeder #(
    .data_width(DW), .address_num(AW), .kernel_size(K), .img_width(W)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .wr_data_g(wr_data_g),
    .adrs_out(adrs_out), .wr_ctrl_g(wr_ctrl_g), .r_ctrl_g(r_ctrl_g),
    .round(round), .neighbour_in_flag(neighbour_in_flag), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_active && !m_done && (m_pix < int'(K));
  endfunction

  task automatic model_reset();
    m_active = 0; m_col = 0; m_pix = 0; m_done = 0;
    e_wr = 0; e_adr = 0; e_data = '0;
  endtask

  // One clock edge of the handshake rules, given the inputs seen at that edge.
  task automatic model_step(input bit st, input bit v, input logic [DW-1:0] d, input bit rd);
    bit prev_wr;
    bit rdy;
    prev_wr = e_wr;
    rdy     = m_ready();
    e_wr    = 0;
    if (m_done) begin
      m_done = 0; m_active = 0; m_col = 0;
    end else if (!m_active) begin
      if (st) begin m_active = 1; m_col = 0; m_pix = 0; end
    end else if (rdy) begin
      if (v) begin
        e_wr = 1; e_adr = m_pix; e_data = d; m_pix++;
      end
    end else if (rd && !prev_wr) begin
      if (m_col == int'(W) - 1) m_done = 1;
      else begin m_col++; m_pix = 0; end
    end
  endtask

  task automatic check_outputs();
    check("wr_ctrl_g", 32'(wr_ctrl_g), 32'(e_wr));
    check("s_ready",   32'(s_ready),   32'(m_ready()));
    check("busy",      32'(busy),      32'(m_active));
    check("done",      32'(done),      32'(m_done));
    check("round",     32'(round),     32'(m_col));
    check("nbr_flag",  32'(neighbour_in_flag), 32'(m_active && m_col != 0));
    if (e_wr) begin
      check("adrs_out",  32'(adrs_out),  32'(e_adr));
      check("wr_data_g", 32'(wr_data_g), 32'(e_data));
    end
  endtask

  task automatic step(input bit st, input bit v, input logic [DW-1:0] d, input bit rd);
    start = st; s_valid = v; s_data = d; r_ctrl_g = rd;
    @(posedge clk);
    model_step(st, v, d, rd);
    #1;
    check_outputs();
    if (done) done_cnt++;
  endtask

  // Asynchronous reset applied between edges; outputs must clear immediately.
  task automatic do_reset();
    start = 0; s_valid = 0; r_ctrl_g = 0; s_data = '0;
    nrst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_adrs", 32'(adrs_out), 32'd0);
    check("rst_data", 32'(wr_data_g), 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    #3;
    do_reset();
    step(0, 0, '0, 0);

    // Column 0: five back-to-back pixels.
    step(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, DW'(16'h0011 + i), 0);
    check("t1_sready_low", 32'(s_ready), 32'd0);
    check("t1_last_adr",   32'(adrs_out), 32'd4);
    // Read strobe in the last-strobe cycle is ignored, next one is honoured.
    step(0, 0, '0, 1);
    check("t3_round_hold", 32'(round), 32'd0);
    step(0, 0, '0, 1);
    check("t3_round_1", 32'(round), 32'd1);
    check("t3_nbr_1",   32'(neighbour_in_flag), 32'd1);
    check("t3_sready",  32'(s_ready), 32'd1);

    // Column 1: gapped valid, read strobes and stray starts throughout.
    for (int i = 0; i < 10; i++) step(i % 3 == 0, i % 2 == 0, DW'(16'h0100 + i), 1);
    check("t2_last_adr", 32'(adrs_out), 32'd4);
    step(1, 0, '0, 1);
    step(1, 0, '0, 1);
    check("t6_round_2", 32'(round), 32'd2);

    // Column 2, then band end.
    for (int i = 0; i < 5; i++) step(1, 1, DW'($urandom), 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    check("t4_done_once", 32'(done_cnt), 32'd1);
    check("t4_round_0",   32'(round), 32'd0);
    check("t4_busy_0",    32'(busy), 32'd0);

    // Reset mid-column after address 2 is written.
    step(1, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, DW'(16'h0200 + i), 0);
    do_reset();
    step(0, 1, 16'h0BAD, 1);
    step(1, 1, 16'h0BAD, 0);
    for (int i = 0; i < 5; i++) step(0, 1, DW'(16'h0300 + i), 0);
    check("t5_fill_adr", 32'(adrs_out), 32'd4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(299) == 0) do_reset();
      step($urandom_range(7) == 0, $urandom_range(3) != 0, DW'($urandom),
           $urandom_range(2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
